// File: rtl/reg_alu_pkg.sv
// Shared opcodes, FSM states and decode helpers for the register ALU.
package reg_alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPW-1:0] OP_MOV  = 4'b0001;
    localparam logic [OPW-1:0] OP_MOVI = 4'b0010;
    localparam logic [OPW-1:0] OP_NOT  = 4'b0011;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0100;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0101;
    localparam logic [OPW-1:0] OP_OR   = 4'b0110;
    localparam logic [OPW-1:0] OP_AND  = 4'b0111;
    localparam logic [OPW-1:0] OP_XOR  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    // True for every legal opcode that writes its destination register.
    function automatic logic op_writes(input logic [OPW-1:0] k);
        return (k >= OP_MOV) && (k <= OP_XOR);
    endfunction

endpackage

// File: rtl/reg_alu_core.sv
// Purely combinational ALU: result, carry/borrow and illegal-opcode decode.
module reg_alu_core
    import reg_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OPW-1:0]   i_kop,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_result_c,
    output logic             o_carry_c,
    output logic             o_illegal_c
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Extra top bit carries the add carry-out / subtract borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Opcode decode; carry stays clear for everything except ADD/SUB.
    always_comb begin
        o_result_c  = '0;
        o_carry_c   = 1'b0;
        o_illegal_c = 1'b0;
        case (i_kop)
            OP_NOP:  o_result_c = '0;
            OP_MOV:  o_result_c = i_b;
            OP_MOVI: o_result_c = i_imm;
            OP_NOT:  o_result_c = ~i_a;
            OP_ADD: begin
                o_result_c = w_sum[WIDTH-1:0];
                o_carry_c  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result_c = w_diff[WIDTH-1:0];
                o_carry_c  = w_diff[WIDTH];
            end
            OP_OR:   o_result_c = i_a | i_b;
            OP_AND:  o_result_c = i_a & i_b;
            OP_XOR:  o_result_c = i_a ^ i_b;
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_alu_exec.sv
// Three-phase (accept / execute / writeback) register-file ALU.
module reg_alu_exec
    import reg_alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NREG  = 4,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   kop,
    input  logic [RW-1:0]    reg_dst,
    input  logic [RW-1:0]    reg_src,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             cf,
    output logic             err,
    input  logic [RW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    state_t           r_state;
    logic             r_in_ready;
    logic [OPW-1:0]   r_kop;
    logic [RW-1:0]    r_dst;
    logic [RW-1:0]    r_src;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_illegal;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_res;
    logic             r_zf;
    logic             r_cf;
    logic             r_out_valid;
    logic             r_err;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_illegal;

    // Operands come from the captured register indices, not the live inputs.
    assign w_a = r_regs[r_dst];
    assign w_b = r_regs[r_src];

    reg_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_kop       (r_kop),
        .i_a         (w_a),
        .i_b         (w_b),
        .i_imm       (r_imm),
        .o_result_c  (w_result),
        .o_carry_c   (w_carry),
        .o_illegal_c (w_illegal)
    );

    // Sequencer, operand/result latches, register file and visible flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_kop       <= '0;
            r_dst       <= '0;
            r_src       <= '0;
            r_imm       <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
            r_res       <= '0;
            r_zf        <= 1'b0;
            r_cf        <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_kop      <= kop;
                        r_dst      <= reg_dst;
                        r_src      <= reg_src;
                        r_imm      <= imm;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result  <= w_result;
                    r_carry   <= w_carry;
                    r_illegal <= w_illegal;
                    r_state   <= ST_WB;
                end
                ST_WB: begin
                    if (r_illegal) begin
                        r_err <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b1;
                        if (op_writes(r_kop)) begin
                            r_regs[r_dst] <= r_result;
                            r_res         <= r_result;
                            r_zf          <= (r_result == '0);
                            r_cf          <= r_carry;
                        end
                    end
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign res       = r_res;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign rd_data   = r_regs[rd_sel];

endmodule

// File: tb/tb_reg_alu_exec.sv
// Randomized bench for reg_alu_exec against a transaction-level reference model.
module tb_reg_alu_exec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] kop;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic [7:0] imm;
    logic       out_valid;
    logic [7:0] res;
    logic       zf;
    logic       cf;
    logic       err;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;

    logic        h_rst_n;
    logic        h_in_valid;
    logic        h_in_ready;
    logic [3:0]  h_kop;
    logic [2:0]  h_dst;
    logic [2:0]  h_src;
    logic [15:0] h_imm;
    logic        h_out_valid;
    logic [15:0] h_res;
    logic        h_zf;
    logic        h_cf;
    logic        h_err;
    logic [2:0]  h_rd_sel;
    logic [15:0] h_rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    reg_alu_exec dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .kop(kop), .reg_dst(reg_dst), .reg_src(reg_src), .imm(imm),
        .out_valid(out_valid), .res(res), .zf(zf), .cf(cf), .err(err),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    reg_alu_exec #(.WIDTH(16), .NREG(8)) dut16 (
        .clk(clk), .rst_n(h_rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .kop(h_kop), .reg_dst(h_dst), .reg_src(h_src), .imm(h_imm),
        .out_valid(h_out_valid), .res(h_res), .zf(h_zf), .cf(h_cf), .err(h_err),
        .rd_sel(h_rd_sel), .rd_data(h_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction in flight, completes two edges after acceptance.
    int m_regs [4];
    int m_res;
    bit m_zf, m_cf, m_ov, m_err;
    int m_busy;
    int p_kop, p_dst, p_src, p_imm;
    int m_a, m_b, m_r;
    bit m_c, m_wr;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_res = 0; m_zf = 0; m_cf = 0; m_ov = 0; m_err = 0;
            m_busy = 0;
            chk_en = 1'b1;
        end else begin
            m_ov = 0;
            m_err = 0;
            if (m_busy == 2) begin
                m_busy = 1;
            end else if (m_busy == 1) begin
                m_a = m_regs[p_dst];
                m_b = m_regs[p_src];
                m_r = 0; m_c = 0; m_wr = 1;
                case (p_kop)
                    0: begin m_wr = 0; m_ov = 1; end
                    1: m_r = m_b;
                    2: m_r = p_imm;
                    3: m_r = 255 - m_a;
                    4: begin m_r = (m_a + m_b) % 256; m_c = (m_a + m_b) > 255; end
                    5: begin m_r = (m_a - m_b + 256) % 256; m_c = m_a < m_b; end
                    6: m_r = m_a | m_b;
                    7: m_r = m_a & m_b;
                    8: m_r = m_a ^ m_b;
                    default: begin m_wr = 0; m_err = 1; end
                endcase
                if (m_wr) begin
                    m_regs[p_dst] = m_r;
                    m_res = m_r;
                    m_zf = (m_r == 0);
                    m_cf = m_c;
                    m_ov = 1;
                end
                m_busy = 0;
            end else if (in_valid) begin
                p_kop = int'(kop); p_dst = int'(reg_dst);
                p_src = int'(reg_src); p_imm = int'(imm);
                m_busy = 2;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  32'(in_ready),  32'(m_busy == 0));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("err",       32'(err),       32'(m_err));
            check("res",       32'(res),       32'(m_res));
            check("zf",        32'(zf),        32'(m_zf));
            check("cf",        32'(cf),        32'(m_cf));
            check("rd_data",   32'(rd_data),   32'(m_regs[rd_sel]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_sel = 2'($urandom);
    endtask

    task automatic issue(input int k, input int d, input int s, input int im);
        int n = 0;
        kop = 4'(k); reg_dst = 2'(d); reg_src = 2'(s); imm = 8'(im);
        in_valid = 1'b1;
        while (!in_ready && n < 8) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready %0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        kop = 4'($urandom); reg_dst = 2'($urandom); reg_src = 2'($urandom); imm = 8'($urandom);
    endtask

    task automatic issue_wait(input int k, input int d, input int s, input int im);
        issue(k, d, s, im);
        tick();
        tick();
    endtask

    task automatic chk_reg(input string name, input int sel, input int exp);
        tick();
        rd_sel = 2'(sel);
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic h_issue(input int k, input int d, input int s, input int im);
        int n = 0;
        h_kop = 4'(k); h_dst = 3'(d); h_src = 3'(s); h_imm = 16'(im);
        h_in_valid = 1'b1;
        while (!h_in_ready && n < 8) begin
            tick();
            n++;
        end
        if (!h_in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL h_accept_timeout: in_ready %0b required 1", h_in_ready);
        end
        tick();
        h_in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int ovs;
        rst_n = 1'b0; in_valid = 1'b0; kop = '0; reg_dst = '0; reg_src = '0; imm = '0; rd_sel = '0;
        h_rst_n = 1'b0; h_in_valid = 1'b0; h_kop = '0; h_dst = '0; h_src = '0; h_imm = '0; h_rd_sel = '0;
        tick();
        tick();
        rst_n = 1'b1;
        h_rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res", 32'(res), 32'h0);
        check("rst_flags", 32'({zf, cf, out_valid, err}), 32'h0);
        chk_reg("rst_dx", 3, 0);

        // MOVI AX,5A; MOVI BX,0F; AND AX,BX with latency probe
        issue_wait(2, 0, 0, 'h5A);
        check("movi_ax_res", 32'(res), 32'h5A);
        issue_wait(2, 1, 0, 'h0F);
        issue(7, 0, 1, 0);
        check("lat_exec_no_ov", 32'(out_valid), 32'd0);
        tick();
        check("lat_wb_no_ov", 32'(out_valid), 32'd0);
        tick();
        check("lat_done_ov", 32'(out_valid), 32'd1);
        check("and_res", 32'(res), 32'h0A);
        check("and_zf_cf", 32'({zf, cf}), 32'h0);
        chk_reg("and_ax", 0, 'h0A);

        // FF + 01 wraps to 0 with carry
        issue_wait(2, 2, 0, 'hFF);
        issue_wait(2, 3, 0, 'h01);
        issue_wait(4, 2, 3, 0);
        check("add_res", 32'(res), 32'h00);
        check("add_zf_cf", 32'({zf, cf}), 32'h3);
        chk_reg("add_cx", 2, 0);

        // 03 - 05 borrows; AND BX,BX keeps BX
        issue_wait(2, 0, 0, 'h03);
        issue_wait(2, 1, 0, 'h05);
        issue_wait(5, 0, 1, 0);
        check("sub_res", 32'(res), 32'hFE);
        check("sub_zf_cf", 32'({zf, cf}), 32'h1);
        chk_reg("sub_ax", 0, 'hFE);
        issue_wait(7, 1, 1, 0);
        check("andself_res", 32'(res), 32'h05);
        check("andself_zf_cf", 32'({zf, cf}), 32'h0);

        // Illegal opcode with in_valid held high for nine edges
        errs = 0; ovs = 0;
        kop = 4'hF; reg_dst = 2'd1; reg_src = 2'd0; imm = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            errs += int'(err);
            ovs += int'(out_valid);
        end
        in_valid = 1'b0;
        check("illegal_err_pulses", 32'(errs), 32'd3);
        check("illegal_ov_pulses", 32'(ovs), 32'd0);
        check("illegal_res_kept", 32'(res), 32'h05);
        chk_reg("illegal_bx_kept", 1, 5);

        // Reset during EXEC of ADD aborts it
        issue_wait(2, 2, 0, 'hFF);
        issue_wait(2, 3, 0, 'h01);
        issue(4, 2, 3, 0);
        rst_n = 1'b0;
        tick();
        check("abort_no_ov", 32'({out_valid, err}), 32'h0);
        rst_n = 1'b1;
        tick();
        check("abort_no_ov2", 32'({out_valid, err}), 32'h0);
        chk_reg("abort_cx", 2, 0);

        // 16-bit / 8-register build
        h_issue(2, 2, 0, 'hFFFF);
        check("w16_movi_res", 32'(h_res), 32'hFFFF);
        h_issue(2, 3, 0, 'h0001);
        h_issue(4, 2, 3, 0);
        check("w16_add_res", 32'(h_res), 32'h0);
        check("w16_add_zf_cf", 32'({h_zf, h_cf}), 32'h3);
        h_rd_sel = 3'd2;
        #1;
        check("w16_cx", 32'(h_rd_data), 32'h0);

        // Randomized traffic with idle gaps and occasional mid-flight resets
        for (int t = 0; t < 400; t++) begin
            int k;
            int gap;
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            issue(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 39) == 0) begin
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) tick();
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
